instruction_fetch: RTL and testbench

- Fetch stage directly downstream of program_counter.
- Takes the current PC, issues word reads on the instruction-memory request/response bus, and tracks outstanding requests.
- Buffers returned instructions with their PC in a small in-order queue that feeds decode through a valid/ready handshake.
- Drives o_Advance, the PC-increment enable, and handles redirects by flushing the queue and discarding stale responses.

---
 rtl/instruction_fetch.sv | 137 +++++++++++++
 tb/tb_instruction_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: issues word reads for the current PC, limits in-flight requests to free queue slots,
// and hands returned instructions to decode in order. Define FETCH_MISALIGN_CHECK_EN to trap unaligned PCs.
module instruction_fetch #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32
) (
   input  logic              i_Clock,
   input  logic              i_Reset,
   input  logic [ADDR_W-1:0] i_PC,
   output logic              o_Advance,
   input  logic              i_Redirect,
   output logic              o_ImemReqValid,
   output logic [ADDR_W-1:0] o_ImemReqAddr,
   input  logic              i_ImemReqReady,
   input  logic              i_ImemRspValid,
   input  logic [31:0]       i_ImemRspData,
   output logic              o_InstrValid,
   output logic [ADDR_W-1:0] o_InstrPC,
   output logic [31:0]       o_Instr,
   input  logic              i_InstrReady,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic              o_InstrMisaligned,
`endif
   output logic              o_Busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_W-1:0] pcf_q [DEPTH], pcf_d [DEPTH];
   logic [ADDR_W-1:0] qpc_q [DEPTH], qpc_d [DEPTH];
   logic [31:0]       qins_q [DEPTH], qins_d [DEPTH];
   logic [PW-1:0]     pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d, q_wr_q, q_wr_d, q_rd_q, q_rd_d;
   logic [CW-1:0]     count_q, count_d, outst_q, outst_d, drop_q, drop_d;
   logic              mis, credit, accept, rsp_take, rsp_drop, mis_push, push, pop;
   logic [ADDR_W-1:0] push_pc;
   logic [31:0]       push_ins;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic [DEPTH-1:0]  qmis_q, qmis_d;
   logic              hold_q, hold_d;
`endif

   always_comb begin
      mis = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis = i_PC[1:0] != 2'b00;
`endif
      credit = ({1'b0, count_q} + {1'b0, outst_q}) < {1'b0, FULL};
      o_ImemReqValid = !i_Reset && !i_Redirect && credit && !mis;
      accept = o_ImemReqValid && i_ImemReqReady;
      rsp_take = i_ImemRspValid && drop_q == '0;
      rsp_drop = i_ImemRspValid && drop_q != '0;
      mis_push = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      // the trap entry waits for in-flight reads so it stays in program order and never races a response push
      mis_push = mis && !hold_q && !i_Reset && !i_Redirect && credit && outst_q == '0;
`endif
      pop = o_InstrValid && i_InstrReady;
      push = rsp_take || mis_push;
      push_pc = mis_push ? i_PC : pcf_q[pcf_rd_q];
      push_ins = mis_push ? 32'h0 : i_ImemRspData;
      pcf_d = pcf_q;
      qpc_d = qpc_q;
      qins_d = qins_q;
      if (i_Redirect) begin
         pcf_wr_d = '0;
         pcf_rd_d = '0;
         q_wr_d = '0;
         q_rd_d = '0;
         count_d = '0;
         outst_d = '0;
         drop_d = drop_q + outst_q - CW'(i_ImemRspValid);
      end else begin
         if (accept) pcf_d[pcf_wr_q] = i_PC;
         if (push) qpc_d[q_wr_q] = push_pc;
         if (push) qins_d[q_wr_q] = push_ins;
         pcf_wr_d = pcf_wr_q + PW'(accept);
         pcf_rd_d = pcf_rd_q + PW'(rsp_take);
         q_wr_d = q_wr_q + PW'(push);
         q_rd_d = q_rd_q + PW'(pop);
         count_d = count_q + CW'(push) - CW'(pop);
         outst_d = outst_q + CW'(accept) - CW'(rsp_take);
         drop_d = drop_q - CW'(rsp_drop);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      qmis_d = qmis_q;
      if (push && !i_Redirect) qmis_d[q_wr_q] = mis_push;
      hold_d = !i_Redirect && (hold_q || mis_push);
`endif
   end

   always_ff @(posedge i_Clock or posedge i_Reset)
      if (i_Reset) begin
         pcf_q <= '{default: '0};
         qpc_q <= '{default: '0};
         qins_q <= '{default: '0};
         pcf_wr_q <= '0;
         pcf_rd_q <= '0;
         q_wr_q <= '0;
         q_rd_q <= '0;
         count_q <= '0;
         outst_q <= '0;
         drop_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         qmis_q <= '0;
         hold_q <= 1'b0;
`endif
      end else begin
         pcf_q <= pcf_d;
         qpc_q <= qpc_d;
         qins_q <= qins_d;
         pcf_wr_q <= pcf_wr_d;
         pcf_rd_q <= pcf_rd_d;
         q_wr_q <= q_wr_d;
         q_rd_q <= q_rd_d;
         count_q <= count_d;
         outst_q <= outst_d;
         drop_q <= drop_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         qmis_q <= qmis_d;
         hold_q <= hold_d;
`endif
      end

   always_ff @(posedge i_Clock)
      if (!i_Reset) assert (!(rsp_take && !i_Redirect && count_q == FULL));

   assign o_ImemReqAddr = i_PC;
   assign o_Advance = accept;
   assign o_InstrValid = count_q != '0;
   assign o_InstrPC = o_InstrValid ? qpc_q[q_rd_q] : '0;
   assign o_Instr = o_InstrValid ? qins_q[q_rd_q] : '0;
   assign o_Busy = outst_q != '0 || drop_q != '0;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign o_InstrMisaligned = o_InstrValid && qmis_q[q_rd_q];
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench with a program-counter model and an in-order variable-latency memory.
module tb_instruction_fetch;
   logic        i_Clock, i_Reset, i_Redirect, i_ImemReqReady, i_ImemRspValid, i_InstrReady;
   logic [31:0] i_PC, i_ImemRspData;
   logic        o_Advance, o_ImemReqValid, o_InstrValid, o_Busy;
   logic [31:0] o_ImemReqAddr, o_InstrPC, o_Instr;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        o_InstrMisaligned;
`endif

   int checks, errors, cyc, lat, acc_count;
   logic [31:0] pc, redir_pc;
   logic [31:0] mq_addr [$];
   int          mq_due [$];
   logic [31:0] log_pc [$], log_ins [$];

   instruction_fetch #(.DEPTH(2), .ADDR_W(32)) dut (
      .i_Clock(i_Clock), .i_Reset(i_Reset), .i_PC(i_PC), .o_Advance(o_Advance),
      .i_Redirect(i_Redirect), .o_ImemReqValid(o_ImemReqValid), .o_ImemReqAddr(o_ImemReqAddr),
      .i_ImemReqReady(i_ImemReqReady), .i_ImemRspValid(i_ImemRspValid), .i_ImemRspData(i_ImemRspData),
      .o_InstrValid(o_InstrValid), .o_InstrPC(o_InstrPC), .o_Instr(o_Instr), .i_InstrReady(i_InstrReady),
`ifdef FETCH_MISALIGN_CHECK_EN
      .o_InstrMisaligned(o_InstrMisaligned),
`endif
      .o_Busy(o_Busy)
   );

   initial begin
      i_Clock = 1'b0;
      forever #5 i_Clock = ~i_Clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] f(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive();
      i_PC = pc;
      i_ImemRspValid = mq_addr.size() > 0 && mq_due[0] <= cyc;
      i_ImemRspData = i_ImemRspValid ? f(mq_addr[0]) : 32'h0;
   endtask

   // samples the current cycle, crosses one clock edge, then updates the PC and memory models
   task automatic cycle();
      logic acc, rsp;
      logic [31:0] addr;
      acc = o_ImemReqValid && i_ImemReqReady;
      rsp = i_ImemRspValid;
      addr = o_ImemReqAddr;
      chk("advance", o_Advance, acc);
      chk("req_addr", o_ImemReqAddr, pc);
      if (o_InstrValid && i_InstrReady) begin
         log_pc.push_back(o_InstrPC);
         log_ins.push_back(o_Instr);
      end
      @(posedge i_Clock);
      #1;
      if (rsp) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      if (acc) begin
         mq_addr.push_back(addr);
         mq_due.push_back(cyc + lat);
         acc_count++;
      end
      pc = i_Redirect ? redir_pc : acc ? pc + 32'd4 : pc;
      i_Redirect = 1'b0;
      cyc++;
      drive();
      #1;
   endtask

   task automatic do_reset(input logic [31:0] base);
      i_Reset = 1'b1;
      mq_addr.delete();
      mq_due.delete();
      log_pc.delete();
      log_ins.delete();
      pc = base;
      cyc = 0;
      lat = 1;
      acc_count = 0;
      i_Redirect = 1'b0;
      i_ImemReqReady = 1'b1;
      i_InstrReady = 1'b1;
      drive();
      repeat (2) @(posedge i_Clock);
      #1;
   endtask

   task automatic release_reset();
      i_Reset = 1'b0;
      drive();
      #1;
   endtask

   task automatic run_until(input int n, input int max);
      for (int i = 0; i < max && log_pc.size() < n; i++) cycle();
      chk("log_size", log_pc.size() >= n, 1);
   endtask

   task automatic check_seq(input string tag, input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_pc"}, log_pc[i], base + 32'(4 * i));
         chk({tag, "_ins"}, log_ins[i], f(base + 32'(4 * i)));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      redir_pc = 32'h0;
      // reset state and basic streaming with 1-cycle memory
      do_reset(32'h0);
      chk("rst_reqvalid", o_ImemReqValid, 0);
      chk("rst_instrvalid", o_InstrValid, 0);
      chk("rst_advance", o_Advance, 0);
      chk("rst_busy", o_Busy, 0);
      chk("rst_instrpc", o_InstrPC, 0);
      chk("rst_instr", o_Instr, 0);
      release_reset();
      chk("t1_req_c0", o_ImemReqValid, 1);
      chk("t1_valid_c0", o_InstrValid, 0);
      cycle();
      chk("t1_valid_c1", o_InstrValid, 0);
      chk("t1_busy_c1", o_Busy, 1);
      cycle();
      chk("t1_valid_c2", o_InstrValid, 1);
      chk("t1_pc_c2", o_InstrPC, 32'h0);
      chk("t1_ins_c2", o_Instr, f(32'h0));
      cycle();
      chk("t1_valid_c3", o_InstrValid, 1);
      chk("t1_pc_c3", o_InstrPC, 32'h4);
      run_until(8, 60);
      check_seq("t1", 8, 32'h0);

      // decode stall: only DEPTH requests may be in flight or queued
      do_reset(32'h0);
      release_reset();
      i_InstrReady = 1'b0;
      repeat (6) cycle();
      chk("t2_accepts", acc_count, 2);
      chk("t2_reqvalid", o_ImemReqValid, 0);
      chk("t2_advance", o_Advance, 0);
      chk("t2_valid", o_InstrValid, 1);
      chk("t2_head_pc", o_InstrPC, 32'h0);
      i_InstrReady = 1'b1;
      run_until(6, 60);
      check_seq("t2", 6, 32'h0);

      // request-ready toggling
      do_reset(32'h0);
      release_reset();
      for (int i = 0; i < 80 && log_pc.size() < 6; i++) begin
         i_ImemReqReady = (i % 2) == 0;
         #1;
         cycle();
      end
      chk("t3_log_size", log_pc.size() >= 6, 1);
      check_seq("t3", 6, 32'h0);
      i_ImemReqReady = 1'b1;

      // redirect with two stale responses in a 3-cycle memory
      do_reset(32'h0);
      lat = 3;
      release_reset();
      cycle();
      cycle();
      chk("t4_full_reqvalid", o_ImemReqValid, 0);
      chk("t4_busy_pre", o_Busy, 1);
      i_Redirect = 1'b1;
      redir_pc = 32'h100;
      #1;
      chk("t4_redirect_reqvalid", o_ImemReqValid, 0);
      cycle();
      chk("t4_stale_rsp1", i_ImemRspValid, 1);
      chk("t4_busy_drop1", o_Busy, 1);
      chk("t4_req_new", o_ImemReqValid, 1);
      chk("t4_req_addr_new", o_ImemReqAddr, 32'h100);
      cycle();
      chk("t4_stale_rsp2", i_ImemRspValid, 1);
      chk("t4_busy_drop2", o_Busy, 1);
      chk("t4_no_valid", o_InstrValid, 0);
      run_until(3, 60);
      check_seq("t4", 3, 32'h100);

      // asynchronous reset mid-burst
      do_reset(32'h0);
      release_reset();
      i_InstrReady = 1'b0;
      repeat (2) cycle();
      chk("t5_pre_valid", o_InstrValid, 1);
      chk("t5_pre_busy", o_Busy, 1);
      #2;
      i_Reset = 1'b1;
      #1;
      chk("t5_async_reqvalid", o_ImemReqValid, 0);
      chk("t5_async_valid", o_InstrValid, 0);
      chk("t5_async_advance", o_Advance, 0);
      chk("t5_async_busy", o_Busy, 0);
      chk("t5_async_pc", o_InstrPC, 0);
      do_reset(32'h0);
      release_reset();
      run_until(4, 60);
      check_seq("t5", 4, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
      // unaligned PC becomes a flagged zero entry and stalls the PC until redirect
      do_reset(32'h102);
      release_reset();
      chk("t6_reqvalid_c0", o_ImemReqValid, 0);
      chk("t6_advance_c0", o_Advance, 0);
      cycle();
      chk("t6_valid", o_InstrValid, 1);
      chk("t6_pc", o_InstrPC, 32'h102);
      chk("t6_ins", o_Instr, 32'h0);
      chk("t6_mis", o_InstrMisaligned, 1);
      cycle();
      repeat (3) begin
         chk("t6_hold_reqvalid", o_ImemReqValid, 0);
         chk("t6_hold_valid", o_InstrValid, 0);
         cycle();
      end
      i_Redirect = 1'b1;
      redir_pc = 32'h104;
      #1;
      cycle();
      chk("t6_req_after", o_ImemReqValid, 1);
      chk("t6_addr_after", o_ImemReqAddr, 32'h104);
      run_until(2, 40);
      chk("t6_log_pc", log_pc[1], 32'h104);
      chk("t6_log_ins", log_ins[1], f(32'h104));
      chk("t6_mis_clear", o_InstrMisaligned, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
